// File: rtl/wt_dcache_miss_arb_pkg.sv
// Shared configuration and cache geometry for the write-through dcache miss arbiter.
// ariane_pkg and wt_cache_pkg carry only the subset this block consumes.
package ariane_pkg;
  typedef struct packed {
    logic DCacheEnable;
  } ariane_cfg_t;

  localparam ariane_cfg_t ArianeDefaultConfig = '{DCacheEnable: 1'b1};
endpackage

package wt_cache_pkg;
  localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
  localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
  localparam int unsigned CACHE_ID_WIDTH      = 3;

  // Port-index width that stays legal for a single-port configuration.
  function automatic int unsigned port_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

package wt_dcache_miss_arb_pkg;
  import wt_cache_pkg::*;

  localparam int unsigned CL_INDEX_WIDTH = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;

  typedef logic [CL_INDEX_WIDTH-1:0] cl_index_t;
endpackage

// File: rtl/wt_dcache_miss_arb_if.sv
// Miss-port and memory-side signal bundle; master is the arbiter's view.
interface wt_dcache_miss_arb_if #(
  parameter int unsigned NumPorts = 3
);
  import wt_cache_pkg::*;

  logic [NumPorts-1:0]        miss_req_i;
  logic [NumPorts-1:0]        miss_ack_o;
  logic [NumPorts-1:0]        miss_replay_o;
  logic [NumPorts-1:0][63:0]  miss_paddr_i;
  logic [NumPorts-1:0]        miss_nc_i;
  logic [NumPorts-1:0][2:0]   miss_size_i;
  logic [NumPorts-1:0]        miss_rtrn_vld_o;

  logic                       mem_req_o;
  logic                       mem_gnt_i;
  logic [63:0]                mem_paddr_o;
  logic                       mem_nc_o;
  logic [2:0]                 mem_size_o;
  logic [CACHE_ID_WIDTH-1:0]  mem_id_o;
  logic                       mem_rtrn_vld_i;
  logic [CACHE_ID_WIDTH-1:0]  mem_rtrn_id_i;

  modport master (
    input  miss_req_i, miss_paddr_i, miss_nc_i, miss_size_i,
           mem_gnt_i, mem_rtrn_vld_i, mem_rtrn_id_i,
    output miss_ack_o, miss_replay_o, miss_rtrn_vld_o,
           mem_req_o, mem_paddr_o, mem_nc_o, mem_size_o, mem_id_o
  );

  modport slave (
    output miss_req_i, miss_paddr_i, miss_nc_i, miss_size_i,
           mem_gnt_i, mem_rtrn_vld_i, mem_rtrn_id_i,
    input  miss_ack_o, miss_replay_o, miss_rtrn_vld_o,
           mem_req_o, mem_paddr_o, mem_nc_o, mem_size_o, mem_id_o
  );
endinterface

// File: rtl/wt_dcache_miss_arb_rr_arb_tree.sv
// Round-robin picker: first requester at or after the externally held priority pointer.
module rr_arb_tree #(
  parameter int unsigned NumIn    = 4,
  parameter int unsigned IdxWidth = 2
) (
  input  logic [IdxWidth-1:0] rr_i,
  input  logic [NumIn-1:0]    req_i,
  output logic                req_o,
  output logic [IdxWidth-1:0] idx_o
);
  logic found;

  always_comb begin
    req_o = |req_i;
    idx_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      int unsigned j;
      j = (32'(rr_i) + i) % NumIn;
      if (!found && req_i[j]) begin
        found = 1'b1;
        idx_o = IdxWidth'(j);
      end
    end
  end
endmodule

// File: rtl/wt_dcache_miss_arb.sv
// Arbitrates read-port cache misses onto one memory request channel, tracks
// outstanding misses per port and replays requests that would alias a pending line.
module wt_dcache_miss_arb
  import wt_cache_pkg::*;
  import wt_dcache_miss_arb_pkg::*;
#(
  parameter int unsigned             NumPorts  = 3,
  parameter ariane_pkg::ariane_cfg_t ArianeCfg = ariane_pkg::ArianeDefaultConfig
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  wt_dcache_miss_arb_if.master bus
);
  localparam int unsigned PW = port_idx_width(NumPorts);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                       state_q, state_d;
  logic [PW-1:0]                ptr_q, ptr_d;
  logic [PW-1:0]                win_q, win_d;
  logic [NumPorts-1:0]          pend_q, pend_d;
  logic [NumPorts-1:0]          pnc_q, pnc_d;
  cl_index_t [NumPorts-1:0]     idx_q, idx_d;
  logic [63:0]                  paddr_q, paddr_d;
  logic                         nc_q, nc_d;
  logic [2:0]                   size_q, size_d;

  logic [NumPorts-1:0]          eligible, rtrn_hit, alias_vec, ack, replay;
  logic [PW-1:0]                win;
  logic                         arb_req, win_nc, collide, mem_req;
  cl_index_t                    win_idx;

  assign eligible = bus.miss_req_i & ~pend_q;

  rr_arb_tree #(
    .NumIn    (NumPorts),
    .IdxWidth (PW)
  ) i_rr_arb_tree (
    .rr_i  (ptr_q),
    .req_i (eligible),
    .req_o (arb_req),
    .idx_o (win)
  );

  always_comb begin
    for (int unsigned k = 0; k < NumPorts; k++) begin
      rtrn_hit[k] = bus.mem_rtrn_vld_i && pend_q[k] &&
                    (bus.mem_rtrn_id_i == CACHE_ID_WIDTH'(k));
    end
  end

  // A disabled dcache makes every miss bypass the alias check.
  assign win_nc  = bus.miss_nc_i[win] | ~ArianeCfg.DCacheEnable;
  assign win_idx = bus.miss_paddr_i[win][DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];

  always_comb begin
    for (int unsigned k = 0; k < NumPorts; k++) begin
      alias_vec[k] = pend_q[k] && !pnc_q[k] && !rtrn_hit[k] &&
                     (idx_q[k] == win_idx) && (win != PW'(k));
    end
  end

  assign collide = !win_nc && (|alias_vec);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    pend_d  = pend_q & ~rtrn_hit;
    pnc_d   = pnc_q;
    idx_d   = idx_q;
    paddr_d = paddr_q;
    nc_d    = nc_q;
    size_d  = size_q;
    ack     = '0;
    replay  = '0;
    mem_req = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_req) begin
          if (collide) begin
            replay[win] = 1'b1;
            ptr_d       = (win == PW'(NumPorts-1)) ? '0 : win + 1'b1;
          end else begin
            win_d       = win;
            paddr_d     = bus.miss_paddr_i[win];
            nc_d        = win_nc;
            size_d      = bus.miss_size_i[win];
            idx_d[win]  = win_idx;
            pnc_d[win]  = win_nc;
            state_d     = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_req = 1'b1;
        if (bus.mem_gnt_i) begin
          ack[win_q]    = 1'b1;
          pend_d[win_q] = 1'b1;
          ptr_d         = (win_q == PW'(NumPorts-1)) ? '0 : win_q + 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      pend_q  <= '0;
      pnc_q   <= '0;
      idx_q   <= '0;
      paddr_q <= '0;
      nc_q    <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      pend_q  <= pend_d;
      pnc_q   <= pnc_d;
      idx_q   <= idx_d;
      paddr_q <= paddr_d;
      nc_q    <= nc_d;
      size_q  <= size_d;
    end
  end

  assign bus.miss_ack_o      = ack;
  assign bus.miss_replay_o   = replay;
  assign bus.miss_rtrn_vld_o = rtrn_hit;
  assign bus.mem_req_o       = mem_req;
  assign bus.mem_paddr_o     = paddr_q;
  assign bus.mem_nc_o        = nc_q;
  assign bus.mem_size_o      = size_q;
  assign bus.mem_id_o        = CACHE_ID_WIDTH'(win_q);
endmodule

// File: tb/tb_wt_dcache_miss_arb.sv
// Directed bench for the dcache miss arbiter: single miss, aliasing replay,
// noncacheable bypass, reset during issue, and round-robin fairness.
module tb_wt_dcache_miss_arb;
  import wt_cache_pkg::*;

  localparam int unsigned N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wt_dcache_miss_arb_if #(.NumPorts(N)) bus ();

  wt_dcache_miss_arb #(.NumPorts(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [2:0] exp_ack [8] = '{3'b000, 3'b001, 3'b000, 3'b010,
                              3'b000, 3'b100, 3'b000, 3'b001};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned p, input logic [63:0] a,
                         input logic nc, input logic [2:0] sz);
    bus.miss_req_i[p]   = 1'b1;
    bus.miss_paddr_i[p] = a;
    bus.miss_nc_i[p]    = nc;
    bus.miss_size_i[p]  = sz;
  endtask

  task automatic ret(input logic v, input logic [2:0] id);
    bus.mem_rtrn_vld_i = v;
    bus.mem_rtrn_id_i  = id;
  endtask

  initial begin
    logic [2:0] prev;
    rst              = 1'b1;
    bus.miss_req_i   = '0;
    bus.miss_paddr_i = '0;
    bus.miss_nc_i    = '0;
    bus.miss_size_i  = '0;
    bus.mem_gnt_i    = 1'b0;
    ret(1'b0, 3'd0);
    step();
    step();
    rst = 1'b0;

    @(negedge clk);
    chk("rst_mem_req", 64'(bus.mem_req_o), 64'd0);
    chk("rst_ack",     64'(bus.miss_ack_o), 64'd0);
    chk("rst_replay",  64'(bus.miss_replay_o), 64'd0);
    chk("rst_rtrn",    64'(bus.miss_rtrn_vld_o), 64'd0);
    chk("rst_paddr",   bus.mem_paddr_o, 64'd0);
    chk("rst_id",      64'(bus.mem_id_o), 64'd0);
    step();

    // Single uncontended miss on port 0.
    set_req(0, 64'h8000_1040, 1'b0, 3'b111);
    @(negedge clk);
    chk("single_offer_ack", 64'(bus.miss_ack_o), 64'd0);
    chk("single_offer_req", 64'(bus.mem_req_o), 64'd0);
    step();
    @(negedge clk);
    chk("single_issue_req",   64'(bus.mem_req_o), 64'd1);
    chk("single_issue_paddr", bus.mem_paddr_o, 64'h8000_1040);
    chk("single_issue_id",    64'(bus.mem_id_o), 64'd0);
    chk("single_issue_size",  64'(bus.mem_size_o), 64'd7);
    chk("single_nognt_ack",   64'(bus.miss_ack_o), 64'd0);
    step();
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("single_gnt_ack", 64'(bus.miss_ack_o), 64'b001);
    chk("single_gnt_req", 64'(bus.mem_req_o), 64'd1);
    step();
    bus.miss_req_i[0] = 1'b0;
    bus.mem_gnt_i     = 1'b0;

    // Port 1 aliases port 0's pending line.
    set_req(1, 64'h8000_2040, 1'b0, 3'b011);
    @(negedge clk);
    chk("coll_replay",  64'(bus.miss_replay_o), 64'b010);
    chk("coll_mem_req", 64'(bus.mem_req_o), 64'd0);
    chk("coll_ack",     64'(bus.miss_ack_o), 64'd0);
    step();
    ret(1'b1, 3'd0);
    @(negedge clk);
    chk("coll_rtrn0",        64'(bus.miss_rtrn_vld_o), 64'b001);
    chk("coll_retry_replay", 64'(bus.miss_replay_o), 64'd0);
    step();
    ret(1'b0, 3'd0);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("coll_retry_req",   64'(bus.mem_req_o), 64'd1);
    chk("coll_retry_id",    64'(bus.mem_id_o), 64'd1);
    chk("coll_retry_paddr", bus.mem_paddr_o, 64'h8000_2040);
    chk("coll_retry_size",  64'(bus.mem_size_o), 64'd3);
    chk("coll_retry_ack",   64'(bus.miss_ack_o), 64'b010);
    step();
    bus.miss_req_i[1] = 1'b0;
    bus.mem_gnt_i     = 1'b0;
    ret(1'b1, 3'd1);
    @(negedge clk);
    chk("rtrn1", 64'(bus.miss_rtrn_vld_o), 64'b010);
    step();
    ret(1'b1, 3'd5);
    @(negedge clk);
    chk("rtrn_id5_ignored", 64'(bus.miss_rtrn_vld_o), 64'd0);
    step();
    ret(1'b1, 3'd0);
    @(negedge clk);
    chk("rtrn_not_pending", 64'(bus.miss_rtrn_vld_o), 64'd0);
    step();
    ret(1'b0, 3'd0);

    // Noncacheable misses to the same index never alias.
    set_req(0, 64'h1000_0000, 1'b1, 3'b010);
    @(negedge clk);
    chk("nc0_replay", 64'(bus.miss_replay_o), 64'd0);
    step();
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("nc0_ack", 64'(bus.miss_ack_o), 64'b001);
    chk("nc0_nc",  64'(bus.mem_nc_o), 64'd1);
    step();
    bus.miss_req_i[0] = 1'b0;
    bus.mem_gnt_i     = 1'b0;
    set_req(1, 64'h1000_0000, 1'b1, 3'b001);
    @(negedge clk);
    chk("nc1_replay", 64'(bus.miss_replay_o), 64'd0);
    chk("nc1_ack0",   64'(bus.miss_ack_o), 64'd0);
    step();
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    chk("nc1_ack",  64'(bus.miss_ack_o), 64'b010);
    chk("nc1_size", 64'(bus.mem_size_o), 64'd1);
    chk("nc1_id",   64'(bus.mem_id_o), 64'd1);
    step();
    bus.miss_req_i[1] = 1'b0;
    bus.mem_gnt_i     = 1'b0;

    // Reset while port 2's request is being issued.
    set_req(2, 64'h8000_3000, 1'b0, 3'b111);
    @(negedge clk);
    chk("rstiss_replay", 64'(bus.miss_replay_o), 64'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rstiss_req_before", 64'(bus.mem_req_o), 64'd1);
    chk("rstiss_ack_before", 64'(bus.miss_ack_o), 64'd0);
    step();
    rst               = 1'b0;
    bus.miss_req_i[2] = 1'b0;
    @(negedge clk);
    chk("rstiss_req_after", 64'(bus.mem_req_o), 64'd0);
    chk("rstiss_ack_after", 64'(bus.miss_ack_o), 64'd0);
    step();
    ret(1'b1, 3'd0);
    @(negedge clk);
    chk("rstiss_pend0_clr", 64'(bus.miss_rtrn_vld_o), 64'd0);
    step();
    ret(1'b1, 3'd1);
    @(negedge clk);
    chk("rstiss_pend1_clr", 64'(bus.miss_rtrn_vld_o), 64'd0);
    step();
    ret(1'b0, 3'd0);

    // All ports request continuously; each ack is returned on the next cycle.
    set_req(0, 64'h0000_0100, 1'b0, 3'b111);
    set_req(1, 64'h0000_0200, 1'b0, 3'b111);
    set_req(2, 64'h0000_0300, 1'b0, 3'b111);
    bus.mem_gnt_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      prev = (c > 0) ? exp_ack[c-1] : 3'b000;
      if (prev != 3'b000)
        ret(1'b1, (prev == 3'b001) ? 3'd0 : (prev == 3'b010) ? 3'd1 : 3'd2);
      else
        ret(1'b0, 3'd0);
      @(negedge clk);
      chk($sformatf("fair_ack_c%0d", c),  64'(bus.miss_ack_o), 64'(exp_ack[c]));
      chk($sformatf("fair_rtrn_c%0d", c), 64'(bus.miss_rtrn_vld_o), 64'(prev));
      step();
    end
    bus.miss_req_i = '0;
    bus.mem_gnt_i  = 1'b0;
    ret(1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
